// File: rtl/counter_sched_if.sv
// counter_sched_if: request/grant bus between the counter scheduler and its clients.
// master drives req/slot/gojam/ack/ovf_clr; slave returns grant, grant_idx, pend, ovf, tmo_err.
interface counter_sched_if #(
  parameter int NREQ = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req;
  logic            slot;
  logic            gojam;
  logic            ack;
  logic            ovf_clr;
  logic            grant;
  logic [IW-1:0]   grant_idx;
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] ovf;
  logic            tmo_err;

  modport master (
    output req, slot, gojam, ack, ovf_clr,
    input  grant, grant_idx, pend, ovf, tmo_err
  );

  modport slave (
    input  req, slot, gojam, ack, ovf_clr,
    output grant, grant_idx, pend, ovf, tmo_err
  );
endinterface

// File: rtl/counter_sched.sv
// counter_sched: latches increment requests and grants one counter cycle per timer slot.
// Ports: clock, rst (async, active high), bus (counter_sched_if.slave: requests in, grant out).
module counter_sched #(
  parameter int NREQ = 8,
  parameter int TMO  = 15
) (
  input  logic            clock,
  input  logic            rst,
  counter_sched_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO_M1 = 8'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] ovf_q, ovf_d;
  logic            tmo_q, tmo_d;

  logic [IW-1:0]   first_idx;
  logic            clr_en;
  logic [NREQ-1:0] clr_mask;
  logic [NREQ-1:0] ovf_set;

  // Lowest-numbered pending bit wins the grant.
  always_comb begin
    first_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend_q[i]) first_idx = IW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    clr_en  = 1'b0;
    if (bus.gojam) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (bus.slot && (|pend_q)) begin
            state_d = SERVE;
            idx_d   = first_idx;
          end
        end
        SERVE: begin
          if (bus.ack) begin
            state_d = DONE;
            clr_en  = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == TMO_M1) begin
            // Grant held for TMO clocks without ack: abandon it.
            state_d = IDLE;
            tmo_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A request arriving on the ack edge re-arms the bit instead of overflowing.
  always_comb begin
    clr_mask = '0;
    if (clr_en) clr_mask[idx_q] = 1'b1;
  end

  always_comb begin
    if (bus.gojam) begin
      pend_d  = '0;
      ovf_set = '0;
    end else begin
      pend_d  = (pend_q & ~clr_mask) | bus.req;
      ovf_set = bus.req & pend_q & ~clr_mask;
    end
    ovf_d = (bus.ovf_clr ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant     = (state_q == SERVE);
  assign bus.grant_idx = (state_q == SERVE) ? idx_q : '0;
  assign bus.pend      = pend_q;
  assign bus.ovf       = ovf_q;
  assign bus.tmo_err   = tmo_q;
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: directed checks of counter_sched request latching,
// slot grants, ack, timeout, gojam, overflow and async reset.
module tb_counter_sched;
  logic clock;
  logic rst;
  int   checks;
  int   errors;

  counter_sched_if #(.NREQ(8)) bus ();

  counter_sched #(.NREQ(8), .TMO(15)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] sl_v;
  logic [15:0] ak_v;
  logic [15:0] ge_v;
  logic [2:0]  ix;

  initial begin
    checks = 0;
    errors = 0;
    bus.req = '0;
    bus.slot = 1'b0;
    bus.gojam = 1'b0;
    bus.ack = 1'b0;
    bus.ovf_clr = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_tmo", 32'(bus.tmo_err), 32'd0);
    rst = 1'b0;
    tick();

    // Two requests, lowest wins, second served after DONE
    bus.req = 8'h28;
    tick();
    bus.req = 8'h00;
    chk("t1_pend", 32'(bus.pend), 32'h28);
    chk("t1_nogrant", 32'(bus.grant), 32'd0);
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t1_grant", 32'(bus.grant), 32'd1);
    chk("t1_idx3", 32'(bus.grant_idx), 32'd3);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t1_done_grant", 32'(bus.grant), 32'd0);
    chk("t1_pend_ack", 32'(bus.pend), 32'h20);
    bus.slot = 1'b1;
    tick();
    chk("t1_slot_in_done", 32'(bus.grant), 32'd0);
    tick();
    bus.slot = 1'b0;
    chk("t1_grant2", 32'(bus.grant), 32'd1);
    chk("t1_idx5", 32'(bus.grant_idx), 32'd5);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    chk("t1_pend_empty", 32'(bus.pend), 32'd0);

    // Re-request on ack edge, then overflow and ovf_clr
    bus.req = 8'h04;
    tick();
    bus.req = 8'h00;
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t2_idx2", 32'(bus.grant_idx), 32'd2);
    bus.ack = 1'b1;
    bus.req = 8'h04;
    tick();
    bus.ack = 1'b0;
    chk("t2_pend_rearm", 32'(bus.pend), 32'h04);
    chk("t2_no_ovf", 32'(bus.ovf), 32'h00);
    tick();
    bus.req = 8'h00;
    chk("t2_ovf_set", 32'(bus.ovf), 32'h04);
    chk("t2_pend_kept", 32'(bus.pend), 32'h04);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(bus.ovf), 32'h00);
    bus.ovf_clr = 1'b1;
    bus.req = 8'h04;
    tick();
    bus.ovf_clr = 1'b0;
    bus.req = 8'h00;
    chk("t2_ovf_set_wins", 32'(bus.ovf), 32'h04);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t2_ovf_clr2", 32'(bus.ovf), 32'h00);

    // Timeout: grant high for 15 clocks, low on the 16th
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t3_grant", 32'(bus.grant), 32'd1);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("t3_hold", 32'(bus.grant), 32'd1);
    end
    tick();
    chk("t3_expired", 32'(bus.grant), 32'd0);
    chk("t3_tmo_err", 32'(bus.tmo_err), 32'd1);
    chk("t3_pend_kept", 32'(bus.pend), 32'h04);
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t3_regrant", 32'(bus.grant), 32'd1);
    chk("t3_regrant_idx", 32'(bus.grant_idx), 32'd2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();

    // gojam with all pending and a grant active
    bus.req = 8'hFF;
    tick();
    bus.req = 8'h00;
    chk("t4_pend_ff", 32'(bus.pend), 32'hFF);
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t4_idx0", 32'(bus.grant_idx), 32'd0);
    bus.gojam = 1'b1;
    bus.req = 8'h01;
    tick();
    bus.gojam = 1'b0;
    bus.req = 8'h00;
    chk("t4_grant", 32'(bus.grant), 32'd0);
    chk("t4_pend", 32'(bus.pend), 32'd0);
    chk("t4_tmo_kept", 32'(bus.tmo_err), 32'd1);
    chk("t4_ovf", 32'(bus.ovf), 32'd0);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("t4_ack_idle", 32'(bus.pend), 32'd0);
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t4_slot_empty", 32'(bus.grant), 32'd0);

    // Slots every 2 clocks, ack 3 clocks after each grant
    bus.req = 8'h12;
    tick();
    bus.req = 8'h00;
    sl_v = 16'h5555;
    ak_v = 16'h0208;
    ge_v = 16'h01C7;
    for (int k = 0; k < 16; k++) begin
      bus.slot = sl_v[k];
      bus.ack = ak_v[k];
      tick();
      chk($sformatf("t5_grant_%0d", k), 32'(bus.grant), 32'(ge_v[k]));
      ix = ge_v[k] ? ((k < 6) ? 3'd1 : 3'd4) : 3'd0;
      chk($sformatf("t5_idx_%0d", k), 32'(bus.grant_idx), 32'(ix));
    end
    bus.slot = 1'b0;
    bus.ack = 1'b0;
    chk("t5_pend", 32'(bus.pend), 32'd0);

    // Async reset between edges during SERVE
    bus.req = 8'h08;
    tick();
    bus.req = 8'h00;
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t6_grant", 32'(bus.grant), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_grant", 32'(bus.grant), 32'd0);
    chk("t6_rst_pend", 32'(bus.pend), 32'd0);
    chk("t6_rst_idx", 32'(bus.grant_idx), 32'd0);
    chk("t6_rst_tmo", 32'(bus.tmo_err), 32'd0);
    #1;
    rst = 1'b0;
    tick();
    chk("t6_idle", 32'(bus.grant), 32'd0);
    bus.req = 8'h01;
    tick();
    bus.req = 8'h00;
    bus.slot = 1'b1;
    tick();
    bus.slot = 1'b0;
    chk("t6_resume", 32'(bus.grant), 32'd1);
    chk("t6_resume_idx", 32'(bus.grant_idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
